burst_ram_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the burst RAM (cmd/cmd_en/busy,

---
 rtl/burst_ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : burst_ram_arbiter                                                |
// | Purpose : Round-robin arbiter/sequencer giving two requesters burst access |
// |           to a single cmd/cmd_en/busy burst RAM.                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module burst_ram_arbiter #(
  parameter int ADDR_BITWIDTH = 4,
  parameter int DATA_BITWIDTH = 64,
  parameter int BURST_COUNT   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m0_req,
  input  logic                       m0_we,
  input  logic [ADDR_BITWIDTH-1:0]   m0_addr,
  input  logic [DATA_BITWIDTH-1:0]   m0_wdata,
  output logic                       m0_wnext,
  output logic [DATA_BITWIDTH-1:0]   m0_rdata,
  output logic                       m0_rvalid,
  output logic                       m0_done,
  output logic                       m0_grant,
  input  logic                       m1_req,
  input  logic                       m1_we,
  input  logic [ADDR_BITWIDTH-1:0]   m1_addr,
  input  logic [DATA_BITWIDTH-1:0]   m1_wdata,
  output logic                       m1_wnext,
  output logic [DATA_BITWIDTH-1:0]   m1_rdata,
  output logic                       m1_rvalid,
  output logic                       m1_done,
  output logic                       m1_grant,
  output logic                       ram_cmd,
  output logic                       ram_cmd_en,
  output logic [ADDR_BITWIDTH-1:0]   ram_addr,
  output logic [DATA_BITWIDTH-1:0]   ram_wr_data,
  output logic [DATA_BITWIDTH/8-1:0] ram_data_mask,
  input  logic [DATA_BITWIDTH-1:0]   ram_rd_data,
  input  logic                       ram_rd_data_valid,
  input  logic                       ram_busy
);

  localparam int c_CNT_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam logic [c_CNT_W-1:0]       c_LAST_BEAT = c_CNT_W'(BURST_COUNT - 1);
  localparam logic [ADDR_BITWIDTH-1:0] c_LOW_MASK  = ADDR_BITWIDTH'(BURST_COUNT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WRITE = 2'd2;
  localparam logic [1:0] c_READ  = 2'd3;

  logic [1:0]               r_state;
  logic                     r_gnt0;
  logic                     r_gnt1;
  logic                     r_we;
  logic                     r_last1;   // 1: m1 was served last, so m0 wins a tie
  logic [ADDR_BITWIDTH-1:0] r_addr;
  logic [c_CNT_W-1:0]       r_beat;

  logic w_pick1;
  logic w_any;
  logic w_last_beat;
  logic w_issue;
  logic w_wr;
  logic w_rd;
  logic w_wbeat;
  logic w_rbeat;
  logic w_done;

  assign w_any       = m0_req | m1_req;
  assign w_pick1     = m1_req & (~m0_req | ~r_last1);
  assign w_last_beat = (r_beat == c_LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_we    <= 1'b0;
      r_last1 <= 1'b1;
      r_addr  <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (!ram_busy && w_any) begin
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_we    <= w_pick1 ? m1_we : m0_we;
            r_addr  <= w_pick1 ? m1_addr : m0_addr;
            r_beat  <= '0;
            r_state <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_beat  <= '0;
          r_state <= r_we ? c_WRITE : c_READ;
        end
        c_WRITE: begin
          // Beat 0 went out during ISSUE; the counter's last value is the idle/done cycle.
          if (w_last_beat) begin
            r_state <= c_IDLE;
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_last1 <= r_gnt1;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        c_READ: begin
          if (ram_rd_data_valid) begin
            if (w_last_beat) begin
              r_state <= c_IDLE;
              r_gnt0  <= 1'b0;
              r_gnt1  <= 1'b0;
              r_last1 <= r_gnt1;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign w_issue = (r_state == c_ISSUE);
  assign w_wr    = (r_state == c_WRITE);
  assign w_rd    = (r_state == c_READ);
  assign w_wbeat = (w_issue & r_we) | (w_wr & ~w_last_beat);
  assign w_rbeat = w_rd & ram_rd_data_valid;
  assign w_done  = (w_wr & w_last_beat) | (w_rbeat & w_last_beat);

  assign m0_wnext  = w_wbeat & r_gnt0;
  assign m1_wnext  = w_wbeat & r_gnt1;
  assign m0_rvalid = w_rbeat & r_gnt0;
  assign m1_rvalid = w_rbeat & r_gnt1;
  assign m0_done   = w_done & r_gnt0;
  assign m1_done   = w_done & r_gnt1;
  assign m0_grant  = r_gnt0;
  assign m1_grant  = r_gnt1;
  assign m0_rdata  = ram_rd_data;
  assign m1_rdata  = ram_rd_data;

  assign ram_cmd_en    = w_issue;
  assign ram_cmd       = w_issue & r_we;
  assign ram_addr      = w_issue ? (r_addr & ~c_LOW_MASK) : '0;
  assign ram_wr_data   = r_gnt0 ? m0_wdata : (r_gnt1 ? m1_wdata : '0);
  assign ram_data_mask = '0;

endmodule
`default_nettype wire

// File: tb/tb_burst_ram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_burst_ram_arbiter                                             |
// | Purpose : Self-checking bench for burst_ram_arbiter with a burst RAM model. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_burst_ram_arbiter;
  localparam int AW = 4, DW = 64, BC = 4, RD_LAT = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    req, we, wnext, rvalid, done, grant;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rdata0, rdata1;
  logic          ram_cmd, ram_cmd_en, ram_busy, rd_valid, busy_force, stray;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data, rd_data;
  logic [DW/8-1:0] mask;

  burst_ram_arbiter #(.ADDR_BITWIDTH(AW), .DATA_BITWIDTH(DW), .BURST_COUNT(BC)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_wnext(wnext[0]), .m0_rdata(rdata0), .m0_rvalid(rvalid[0]), .m0_done(done[0]),
    .m0_grant(grant[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_wnext(wnext[1]), .m1_rdata(rdata1), .m1_rvalid(rvalid[1]), .m1_done(done[1]),
    .m1_grant(grant[1]),
    .ram_cmd(ram_cmd), .ram_cmd_en(ram_cmd_en), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_data_mask(mask), .ram_rd_data(rd_data),
    .ram_rd_data_valid(rd_valid), .ram_busy(ram_busy)
  );

  // Burst RAM model: write beats taken from the command cycle on, read beats RD_LAT cycles after it.
  logic [DW-1:0] mem [16];
  int cyc = 0;
  int rd_start = -100;
  int wr_left = 0;
  int wr_idx = 0;
  logic [AW-1:0] rd_base = '0, wr_base = '0;
  logic rd_active;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      rd_start <= -100;
      wr_left  <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (ram_cmd_en && ram_cmd) begin
        mem[ram_addr] <= ram_wr_data;
        wr_base <= ram_addr;
        wr_idx  <= 1;
        wr_left <= BC - 1;
      end else if (wr_left > 0) begin
        mem[wr_base + AW'(wr_idx)] <= ram_wr_data;
        wr_idx  <= wr_idx + 1;
        wr_left <= wr_left - 1;
      end
      if (ram_cmd_en && !ram_cmd) begin
        rd_start <= cyc + RD_LAT;
        rd_base  <= ram_addr;
      end
    end
  end

  assign rd_active = (cyc >= rd_start) && (cyc < rd_start + BC);
  assign rd_valid  = rd_active | stray;
  assign rd_data   = rd_active ? mem[rd_base + AW'(cyc - rd_start)] : '0;
  assign ram_busy  = busy_force;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Grant order log and per-cycle protocol invariants.
  int gq[$];
  logic [1:0] prev_g = 2'b00;
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++)
      if (grant[p] && !prev_g[p]) gq.push_back(p);
    prev_g = grant;
    chk("invariant", {grant == 2'b11, (wnext | rvalid | done) & ~grant, mask != '0}, '0);
  end

  // Reference model: word memory plus round-robin history.
  logic [DW-1:0] shadow [16];
  int last_served;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) shadow[i] = '0;
    last_served = 1;
  endtask

  int res_first [2], res_done [2], res_cmd [2], res_cnt [2];
  logic [AW-1:0] res_addr [2];
  logic          res_rw [2];
  logic [DW-1:0] res_data [2][BC];

  task automatic model_apply(input int p, input bit w, input logic [AW-1:0] a,
                             input logic [DW-1:0] base, input string nm);
    logic [AW-1:0] al;
    al = a & ~AW'(BC - 1);
    for (int i = 0; i < BC; i++) begin
      if (w) shadow[al + AW'(i)] = base + DW'(i);
      else   chk(nm, res_data[p][i], shadow[al + AW'(i)]);
    end
    last_served = p;
  endtask

  task automatic do_burst(input int p, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] base, input bit drop_early);
    int t0, beat;
    bit wn, rv, dn;
    t0 = cyc; beat = 0;
    res_first[p] = -1; res_done[p] = -1; res_cmd[p] = -1; res_cnt[p] = 0;
    req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = base;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      wn = wnext[p]; rv = rvalid[p]; dn = done[p];
      if (grant[p] && ram_cmd_en && res_cmd[p] < 0) begin
        res_cmd[p] = cyc - t0; res_addr[p] = ram_addr; res_rw[p] = ram_cmd;
      end
      if ((wn || rv) && res_first[p] < 0) res_first[p] = cyc - t0;
      if (rv && res_cnt[p] < BC) res_data[p][res_cnt[p]] = (p == 0) ? rdata0 : rdata1;
      if (wn || rv) res_cnt[p]++;
      if (dn) res_done[p] = cyc - t0;
      @(posedge clk); #1;
      if (wn) begin
        beat++;
        wdata[p] = base + DW'(beat);
        if (drop_early) req[p] = 1'b0;
      end
      if (dn) break;
    end
    req[p] = 1'b0;
  endtask

  typedef struct {
    int p; bit w; logic [AW-1:0] a; logic [DW-1:0] base;
    logic [AW-1:0] exp_ram_addr; int exp_first; int exp_done;
  } vec_t;
  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first, nb, extra;
    bit w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] b0, b1;

    tbl[0] = '{0, 1'b1, 4'd4,  64'hA5A5_0000_0000_00A0, 4'd4, 1,  5};
    tbl[1] = '{0, 1'b0, 4'd4,  64'hA5A5_0000_0000_00A0, 4'd4, 11, 14};
    tbl[2] = '{1, 1'b1, 4'd7,  64'hB6B6_0000_0000_00B0, 4'd4, 1,  5};
    tbl[3] = '{1, 1'b0, 4'd5,  64'hB6B6_0000_0000_00B0, 4'd4, 11, 14};
    tbl[4] = '{0, 1'b1, 4'd11, 64'hC7C7_0000_0000_00C0, 4'd8, 1,  5};
    tbl[5] = '{1, 1'b0, 4'd8,  64'hC7C7_0000_0000_00C0, 4'd8, 11, 14};

    rst = 1'b1; req = '0; we = '0; busy_force = 1'b0; stray = 1'b0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_grant", grant, 2'b00);
    chk("reset_strobes", {wnext, rvalid, done}, '0);
    chk("reset_ram", {ram_cmd_en, ram_cmd, ram_addr, ram_wr_data}, '0);

    // Both ports request in the same cycle straight after reset: m0 first, m1 one idle cycle later.
    @(posedge clk); #1;
    gq.delete();
    fork
      do_burst(0, 1'b1, 4'd0, 64'hD0D0_0000_0000_00D0, 1'b0);
      do_burst(1, 1'b1, 4'd8, 64'hE0E0_0000_0000_00E0, 1'b0);
    join
    chk("tie_first_grant", (gq.size() > 0) ? gq[0] : -1, 0);
    chk("tie_m0_done", res_done[0], 5);
    chk("tie_m1_cmd_gap", res_cmd[1], res_done[0] + 2);
    chk("tie_m1_done", res_done[1], 11);
    model_apply(0, 1'b1, 4'd0, 64'hD0D0_0000_0000_00D0, "");
    model_apply(1, 1'b1, 4'd8, 64'hE0E0_0000_0000_00E0, "");

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      do_burst(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].base, 1'b0);
      chk("tbl_cmd_cycle", res_cmd[tbl[i].p], 1);
      chk("tbl_ram_addr", res_addr[tbl[i].p], tbl[i].exp_ram_addr);
      chk("tbl_ram_cmd", res_rw[tbl[i].p], tbl[i].w);
      chk("tbl_first_beat", res_first[tbl[i].p], tbl[i].exp_first);
      chk("tbl_done", res_done[tbl[i].p], tbl[i].exp_done);
      chk("tbl_beats", res_cnt[tbl[i].p], BC);
      for (int b = 0; b < BC; b++) begin
        if (tbl[i].w) chk("tbl_ram_word", mem[tbl[i].exp_ram_addr + AW'(b)], tbl[i].base + DW'(b));
        else          chk("tbl_rdata", res_data[tbl[i].p][b], tbl[i].base + DW'(b));
      end
      model_apply(tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].base, "");
    end

    // Request dropped after the first beat: burst still completes.
    @(posedge clk); #1;
    do_burst(0, 1'b1, 4'd13, 64'h1234_0000_0000_0010, 1'b1);
    chk("drop_req_done", res_done[0], 5);
    chk("drop_req_word3", mem[15], 64'h1234_0000_0000_0013);
    model_apply(0, 1'b1, 4'd13, 64'h1234_0000_0000_0010, "");

    // RAM busy in IDLE holds off the grant.
    busy_force = 1'b1;
    @(posedge clk); #1;
    fork
      do_burst(1, 1'b0, 4'd12, '0, 1'b0);
      begin
        repeat (6) begin
          @(negedge clk);
          chk("busy_no_grant", grant, 2'b00);
        end
        @(posedge clk); #1 busy_force = 1'b0;
      end
    join
    chk("busy_done", res_done[1], 20);
    model_apply(1, 1'b0, 4'd12, '0, "busy_rdata");

    // Stray read-valid while idle is not forwarded.
    @(posedge clk); #1 stray = 1'b1;
    @(negedge clk);
    chk("stray_rvalid", {rvalid, done}, '0);
    @(posedge clk); #1 stray = 1'b0;

    // Both ports held requesting: grants alternate.
    gq.delete();
    first = (last_served == 1) ? 0 : 1;
    fork
      repeat (3) begin
        do_burst(0, 1'b0, 4'd4, '0, 1'b0);
        chk("alt_m0_done_seen", res_done[0] > 0, 1'b1);
        model_apply(0, 1'b0, 4'd4, '0, "alt_m0_rdata");
      end
      repeat (3) begin
        do_burst(1, 1'b0, 4'd8, '0, 1'b0);
        chk("alt_m1_done_seen", res_done[1] > 0, 1'b1);
        model_apply(1, 1'b0, 4'd8, '0, "alt_m1_rdata");
      end
    join
    chk("alt_count", gq.size(), 6);
    for (int k = 0; k < 6; k++)
      chk("alt_order", (k < gq.size()) ? gq[k] : -1, (first + k) % 2);
    last_served = (gq.size() > 0) ? gq[gq.size() - 1] : last_served;

    // Randomized single and concurrent bursts against the model.
    for (int it = 0; it < 30; it++) begin
      w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
      a0 = AW'($urandom_range(0, 15)); a1 = AW'($urandom_range(0, 15));
      b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
      @(posedge clk); #1;
      if ($urandom_range(0, 1) == 1) begin
        gq.delete();
        first = (last_served == 1) ? 0 : 1;
        fork
          do_burst(0, w0, a0, b0, 1'b0);
          do_burst(1, w1, a1, b1, 1'b0);
        join
        chk("rnd_dual_first", (gq.size() > 0) ? gq[0] : -1, first);
        chk("rnd_dual_done", {res_done[0] > 0, res_done[1] > 0}, 2'b11);
        chk("rnd_dual_beats", {res_cnt[0][7:0], res_cnt[1][7:0]}, {8'(BC), 8'(BC)});
        if (first == 0) begin
          model_apply(0, w0, a0, b0, "rnd_rdata");
          model_apply(1, w1, a1, b1, "rnd_rdata");
        end else begin
          model_apply(1, w1, a1, b1, "rnd_rdata");
          model_apply(0, w0, a0, b0, "rnd_rdata");
        end
      end else begin
        first = $urandom_range(0, 1);
        do_burst(first, w0, a0, b0, 1'b0);
        chk("rnd_single_done", res_done[first], w0 ? 5 : 14);
        chk("rnd_single_addr", res_addr[first], a0 & ~AW'(BC - 1));
        model_apply(first, w0, a0, b0, "rnd_rdata");
      end
    end

    // Reset during beat 2 of a read: outputs clear, no done, next request served.
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 4'd4;
    nb = 0;
    for (int k = 0; k < 40 && nb < 3; k++) begin
      @(negedge clk);
      if (rvalid[0]) nb++;
    end
    chk("rst_mid_beats_seen", nb, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs",
        {grant, wnext, rvalid, done, ram_cmd_en, ram_cmd, ram_addr, ram_wr_data, rdata0}, '0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done != 2'b00) extra++;
    end
    chk("rst_mid_no_done", extra, 0);
    model_reset();
    @(posedge clk); #1;
    do_burst(1, 1'b1, 4'd2, 64'hF00D_0000_0000_0000, 1'b0);
    chk("after_rst_done", res_done[1], 5);
    chk("after_rst_word", mem[1], 64'hF00D_0000_0000_0001);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
